// File: rtl/ecall_write_streamer.sv
// Write-ecall byte streamer: reads bytes from data memory with a fixed read
// latency and hands them downstream on an fd-tagged ready/valid stream.
module ecall_write_streamer #(
  parameter int ADDR_W     = 32,
  parameter int MEM_BITS   = 12,
  parameter int NUM_FD     = 4,
  parameter int FD_W       = 2,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [ADDR_W-1:0] req_fd,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [ADDR_W-1:0] req_len,
  output logic              done,
  output logic              err_bad_fd,
  output logic              mem_rden,
  output logic [MEM_BITS-1:0] mem_addr,
  input  logic [7:0]        mem_q,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic [FD_W-1:0]   out_fd,
  output logic [ADDR_W-1:0] bytes_sent
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + RD_LAT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

  state_t state, state_nx;

  logic [ADDR_W-1:0] addr_q, len_q, offset, mem_sum;
  logic [RD_LAT-1:0] pend;
  logic [RD_LAT:0]   pend_sh;
  logic [7:0]        fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count, inflight;
  logic              push, pop, fd_bad;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign fd_bad    = req_fd >= ADDR_W'(NUM_FD);
  assign push      = pend[RD_LAT-1];
  assign out_valid = count != '0;
  assign pop       = out_valid & out_ready;
  assign out_data  = fifo_mem[rd_ptr];
  assign mem_sum   = addr_q + offset;
  assign mem_addr  = mem_rden ? mem_sum[MEM_BITS-1:0] : '0;
  assign pend_sh   = {pend, mem_rden};

  // Reads still travelling through the memory pipeline hold a FIFO credit.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++)
      inflight = inflight + CW'(pend[i]);
  end

  always_comb begin
    state_nx = state;
    mem_rden = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          if (fd_bad)
            state_nx = FINISH;
          else if (req_len == '0)
            state_nx = FINISH;
          else
            state_nx = ISSUE;
        end
      end
      ISSUE: begin
        if ((offset < len_q) &&
            ((count + inflight) < CW'(FIFO_DEPTH)))
          mem_rden = 1'b1;
        if (mem_rden && (offset + ADDR_W'(1) == len_q))
          state_nx = DRAIN;
      end
      DRAIN: begin
        if (count == '0 && inflight == '0)
          state_nx = FINISH;
      end
      FINISH: begin
        if (!req)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      done       <= 1'b1;
      err_bad_fd <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
      offset     <= '0;
      out_fd     <= '0;
      pend       <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      bytes_sent <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++)
        fifo_mem[i] <= '0;
    end else begin
      state <= state_nx;
      pend  <= pend_sh[RD_LAT-1:0];
      if (state == IDLE && req) begin
        addr_q     <= req_addr;
        len_q      <= req_len;
        offset     <= '0;
        out_fd     <= req_fd[FD_W-1:0];
        err_bad_fd <= fd_bad;
        done       <= 1'b0;
      end
      if (state == FINISH)
        done <= 1'b1;
      if (mem_rden)
        offset <= offset + ADDR_W'(1);
      if (push) begin
        fifo_mem[wr_ptr] <= mem_q;
        wr_ptr <= bump(wr_ptr);
      end
      if (pop) begin
        rd_ptr     <= bump(rd_ptr);
        bytes_sent <= bytes_sent + ADDR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_ecall_write_streamer.sv
// Directed bench: two streamers (read latency 1 and 3) share stimulus and a
// byte-wide memory model; streams are collected and compared per scenario.
module tb_ecall_write_streamer;

  logic        clk = 1'b0;
  logic        rst, req, out_ready;
  logic [31:0] req_fd, req_addr, req_len;
  logic        dn [2];
  logic        eb [2];
  logic        rd [2];
  logic        ov [2];
  logic [11:0] ma [2];
  logic [7:0]  mq [2];
  logic [7:0]  od [2];
  logic [1:0]  ofd [2];
  logic [31:0] bs [2];

  logic [7:0]  mem [4096];
  logic [7:0]  pipe [2][3];

  logic [7:0]  got0 [$];
  logic [7:0]  got1 [$];
  logic [11:0] adr0 [$];
  logic [11:0] adr1 [$];
  int          iss [2];
  int          popn [2];
  logic        stall [2];
  logic [7:0]  sdat [2];
  int          rdtot [2];

  int vec = 0;
  int errs = 0;

  ecall_write_streamer #(.RD_LAT(1), .FIFO_DEPTH(4)) u1 (
    .clk(clk), .rst(rst), .req(req), .req_fd(req_fd),
    .req_addr(req_addr), .req_len(req_len), .done(dn[0]),
    .err_bad_fd(eb[0]), .mem_rden(rd[0]), .mem_addr(ma[0]),
    .mem_q(mq[0]), .out_valid(ov[0]), .out_ready(out_ready),
    .out_data(od[0]), .out_fd(ofd[0]), .bytes_sent(bs[0])
  );

  ecall_write_streamer #(.RD_LAT(3), .FIFO_DEPTH(4)) u3 (
    .clk(clk), .rst(rst), .req(req), .req_fd(req_fd),
    .req_addr(req_addr), .req_len(req_len), .done(dn[1]),
    .err_bad_fd(eb[1]), .mem_rden(rd[1]), .mem_addr(ma[1]),
    .mem_q(mq[1]), .out_valid(ov[1]), .out_ready(out_ready),
    .out_data(od[1]), .out_fd(ofd[1]), .bytes_sent(bs[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      pipe[k][0] <= mem[ma[k]];
      pipe[k][1] <= pipe[k][0];
      pipe[k][2] <= pipe[k][1];
    end
  end

  assign mq[0] = pipe[0][0];
  assign mq[1] = pipe[1][2];

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst) begin
        iss[k]   = 0;
        popn[k]  = 0;
        stall[k] = 1'b0;
      end else begin
        if (stall[k])
          check($sformatf("stall_hold%0d", k), {ov[k], od[k]},
                {1'b1, sdat[k]});
        if (rd[k]) begin
          check($sformatf("credit%0d", k),
                32'(iss[k] + 1 - popn[k] <= 4), 32'd1);
          iss[k]++;
          rdtot[k]++;
          if (k == 0) adr0.push_back(ma[k]);
          else        adr1.push_back(ma[k]);
        end
        if (ov[k] && out_ready) begin
          popn[k]++;
          if (k == 0) got0.push_back(od[k]);
          else        got1.push_back(od[k]);
        end
        stall[k] = ov[k] && !out_ready;
        sdat[k]  = od[k];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    got0.delete();
    got1.delete();
    adr0.delete();
    adr1.delete();
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!(dn[0] && dn[1]) && n < budget) begin
      tick();
      n++;
    end
    check("done_wait", 32'(dn[0] && dn[1]), 32'd1);
  endtask

  task automatic set_req(input logic [31:0] fd, input logic [31:0] a,
                         input logic [31:0] l);
    req_fd   = fd;
    req_addr = a;
    req_len  = l;
    req      = 1'b1;
  endtask

  task automatic check_stream(input string tag, input int n,
                              input logic [7:0] e0, input logic [7:0] e1,
                              input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] e [4];
    e = '{e0, e1, e2, e3};
    check({tag, "_n0"}, 32'(got0.size()), 32'(n));
    check({tag, "_n1"}, 32'(got1.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (i < got0.size())
        check($sformatf("%s_d0_%0d", tag, i), 32'(got0[i]), 32'(e[i]));
      if (i < got1.size())
        check($sformatf("%s_d1_%0d", tag, i), 32'(got1[i]), 32'(e[i]));
    end
  endtask

  initial begin
    int n;
    int rd_before [2];
    logic [11:0] ea [4];

    for (int i = 0; i < 4096; i++)
      mem[i] = 8'(i) ^ 8'h5A;
    mem[12'h010] = 8'h41; mem[12'h011] = 8'h42; mem[12'h012] = 8'h43;
    mem[12'hFFE] = 8'hA0; mem[12'hFFF] = 8'hA1;
    mem[12'h000] = 8'hA2; mem[12'h001] = 8'hA3;
    for (int i = 0; i < 6; i++)
      mem[12'h020 + 12'(i)] = 8'hB0 + 8'(i);
    rdtot = '{0, 0};

    rst = 1'b0; req = 1'b0; out_ready = 1'b1;
    req_fd = '0; req_addr = '0; req_len = '0;
    tick(); tick();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst_done%0d", k), 32'(dn[k]), 32'd1);
      check($sformatf("rst_err%0d", k), 32'(eb[k]), 32'd0);
      check($sformatf("rst_rden%0d", k), 32'(rd[k]), 32'd0);
      check($sformatf("rst_addr%0d", k), 32'(ma[k]), 32'd0);
      check($sformatf("rst_valid%0d", k), 32'(ov[k]), 32'd0);
      check($sformatf("rst_data%0d", k), 32'(od[k]), 32'd0);
      check($sformatf("rst_fd%0d", k), 32'(ofd[k]), 32'd0);
      check($sformatf("rst_cnt%0d", k), bs[k], 32'd0);
    end
    rst = 1'b1;
    tick();

    // Basic three-byte write, full-rate downstream.
    clear_q();
    set_req(32'd1, 32'h10, 32'd3);
    tick();
    check("s1_rden", 32'(rd[0]), 32'd1);
    check("s1_addr", 32'(ma[0]), 32'h010);
    tick();
    check("s1_lat_valid", 32'(ov[0]), 32'd0);
    tick();
    check("s1_b0", {31'(od[0]), ov[0]}, {31'h41, 1'b1});
    check("s1_fd", 32'(ofd[0]), 32'd1);
    tick();
    check("s1_b1", {31'(od[0]), ov[0]}, {31'h42, 1'b1});
    tick();
    check("s1_b2", {31'(od[0]), ov[0]}, {31'h43, 1'b1});
    wait_done(40);
    check("s1_cnt0", bs[0], 32'd3);
    check("s1_cnt1", bs[1], 32'd3);
    for (int i = 0; i < 4; i++) tick();
    check("s1_hold_done0", 32'(dn[0]), 32'd1);
    check("s1_hold_done1", 32'(dn[1]), 32'd1);
    check_stream("s1", 3, 8'h41, 8'h42, 8'h43, 8'h00);
    req = 1'b0;
    tick(); tick();
    check("s1_idle_valid", 32'(ov[0] | ov[1]), 32'd0);

    // Same request under a 1,0,0 ready pattern.
    clear_q();
    set_req(32'd1, 32'h10, 32'd3);
    tick();
    n = 0;
    while (!(dn[0] && dn[1]) && n < 80) begin
      out_ready = (n % 3 == 0);
      tick();
      n++;
    end
    out_ready = 1'b1;
    check("s2_done", 32'(dn[0] && dn[1]), 32'd1);
    check_stream("s2", 3, 8'h41, 8'h42, 8'h43, 8'h00);
    check("s2_cnt0", bs[0], 32'd6);
    check("s2_cnt1", bs[1], 32'd6);
    req = 1'b0;
    tick(); tick();

    // Zero length: done dips for one cycle only.
    clear_q();
    set_req(32'd2, 32'h40, 32'd0);
    tick();
    check("s3_dip0", 32'(dn[0]), 32'd0);
    check("s3_dip1", 32'(dn[1]), 32'd0);
    tick();
    check("s3_up0", 32'(dn[0]), 32'd1);
    check("s3_up1", 32'(dn[1]), 32'd1);
    check("s3_cnt0", bs[0], 32'd6);
    check("s3_cnt1", bs[1], 32'd6);
    check("s3_nout", 32'(got0.size() + got1.size()), 32'd0);
    req = 1'b0;
    tick(); tick();

    // Illegal fd: flagged, no reads, no bytes.
    clear_q();
    rd_before = rdtot;
    set_req(32'd7, 32'h10, 32'd5);
    tick();
    check("s4_err0", 32'(eb[0]), 32'd1);
    check("s4_err1", 32'(eb[1]), 32'd1);
    tick(); tick();
    check("s4_done", 32'(dn[0] && dn[1]), 32'd1);
    req = 1'b0;
    tick(); tick();
    check("s4_sticky", 32'(eb[0] && eb[1]), 32'd1);
    check("s4_rden0", 32'(rdtot[0]), 32'(rd_before[0]));
    check("s4_rden1", 32'(rdtot[1]), 32'(rd_before[1]));
    check("s4_nout", 32'(got0.size() + got1.size()), 32'd0);

    // Address wrap at the top of memory; also clears the error.
    clear_q();
    set_req(32'd3, 32'hFFE, 32'd4);
    tick();
    check("s5_errclr0", 32'(eb[0]), 32'd0);
    check("s5_errclr1", 32'(eb[1]), 32'd0);
    wait_done(60);
    check_stream("s5", 4, 8'hA0, 8'hA1, 8'hA2, 8'hA3);
    ea = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
    check("s5_na0", 32'(adr0.size()), 32'd4);
    check("s5_na1", 32'(adr1.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < adr0.size())
        check($sformatf("s5_a0_%0d", i), 32'(adr0[i]), 32'(ea[i]));
      if (i < adr1.size())
        check($sformatf("s5_a1_%0d", i), 32'(adr1[i]), 32'(ea[i]));
    end
    check("s5_cnt0", bs[0], 32'd10);
    req = 1'b0;
    tick(); tick();

    // Reset in the middle of a six-byte transfer.
    clear_q();
    set_req(32'd0, 32'h20, 32'd6);
    tick();
    n = 0;
    while (got0.size() < 2 && n < 30) begin
      tick();
      n++;
    end
    check("s6_pre", 32'(got0.size()), 32'd2);
    rst = 1'b0;
    req = 1'b0;
    tick();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("s6_done%0d", k), 32'(dn[k]), 32'd1);
      check($sformatf("s6_valid%0d", k), 32'(ov[k]), 32'd0);
      check($sformatf("s6_rden%0d", k), 32'(rd[k]), 32'd0);
      check($sformatf("s6_cnt%0d", k), bs[k], 32'd0);
    end
    rst = 1'b1;
    tick();
    check("s6_quiet", 32'(ov[0] | ov[1] | rd[0] | rd[1]), 32'd0);
    clear_q();
    set_req(32'd1, 32'h10, 32'd3);
    tick();
    wait_done(40);
    check_stream("s6", 3, 8'h41, 8'h42, 8'h43, 8'h00);
    check("s6_recnt0", bs[0], 32'd3);
    check("s6_recnt1", bs[1], 32'd3);
    req = 1'b0;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/ecall_write_streamer.md
Name: ecall_write_streamer

Overview:
- Parametrised successor to the single-channel write-ecall byte pusher in the top-level hardware interface.
- Services the CPU's write ecall (fd, address, length): reads bytes from data memory over a port with fixed read latency and emits them on a ready/valid byte stream tagged with the fd.
- The read/ready path is credit-controlled and buffered, so downstream back-pressure never drops or duplicates a byte.
- Also reports completion, bad-fd errors and a running byte count.

Parameters:
- ADDR_W, 32, width of request address and length
- MEM_BITS, 12, data-memory byte-address width; memory address wraps modulo 2^MEM_BITS
- NUM_FD, 4, number of legal fds (0..NUM_FD-1)
- FD_W, 2, width of out_fd (>= clog2(NUM_FD))
- RD_LAT, 1, memory read latency in cycles (rden at cycle t gives mem_q valid at t+RD_LAT); legal range 1..4
- FIFO_DEPTH, 4, output buffer depth; must be >= RD_LAT+1

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-low reset
- req  in  1  write ecall pending; level, held by CPU until done observed
- req_fd  in  ADDR_W  fd argument
- req_addr  in  ADDR_W  start byte address
- req_len  in  ADDR_W  byte count
- done  out  1  high when not transferring (write_ecall_finished)
- err_bad_fd  out  1  sticky until next accepted req; set when req_fd >= NUM_FD
- mem_rden  out  1  memory read enable
- mem_addr  out  MEM_BITS  memory byte address
- mem_q  in  8  memory read data, byte lane
- out_valid  out  1  stream byte valid
- out_ready  in  1  downstream accepts
- out_data  out  8  stream byte
- out_fd  out  FD_W  fd tag, req_fd[FD_W-1:0] latched at accept
- bytes_sent  out  ADDR_W  bytes handed off since reset; wraps

Behaviour:
- Reset (rst==0 at posedge): state=IDLE, done=1, err_bad_fd=0, mem_rden=0, mem_addr=0, out_valid=0, out_data=0, out_fd=0, bytes_sent=0, FIFO emptied, all in-flight reads discarded. Reset mid-transfer aborts with no further output.
- States: IDLE, ISSUE, DRAIN, FINISH.
- IDLE, req==1: latch fd/addr/len, clear err_bad_fd, done<=0, offset<=0.
  - req_fd >= NUM_FD: err_bad_fd<=1, go to FINISH; no reads, no output.
  - len==0: go to FINISH.
  - otherwise: go to ISSUE.
- ISSUE: each cycle, mem_rden=1 iff issued<len and (FIFO occupancy + reads in flight) < FIFO_DEPTH.
  - mem_addr = (addr + offset)[MEM_BITS-1:0]; offset++ per issued read.
  - Go to DRAIN the cycle after the last read is issued.
- Read return: the byte captured RD_LAT cycles after issue is pushed into the FIFO the same cycle. The credit rule guarantees no overflow.
- Output: out_valid = FIFO not empty; out_data = FIFO head. A byte transfers when out_valid & out_ready; pop and bytes_sent++ that cycle. Push and pop in the same cycle keep occupancy unchanged. out_data/out_fd stay stable while out_valid & !out_ready.
- DRAIN: wait until the FIFO is empty and no reads are in flight, then go to FINISH.
- FINISH: done=1. Stay until req==0, then go to IDLE. This prevents re-triggering on a held req.
- Memory address wraps: addr+offset past 2^MEM_BITS-1 continues at 0.
- offset and issued counters are ADDR_W wide; req_len up to 2^ADDR_W-1 is legal.
- Req inputs are ignored outside IDLE; changes mid-transfer have no effect.

Test Plan:
- fd=1, addr=0x10, len=3, mem[0x10..0x12]=41,42,43, out_ready=1 -> out_data 41,42,43 on consecutive cycles after RD_LAT, out_fd=1, bytes_sent=3, done back to 1; done stays 1 and no repeat output while req is held; IDLE after req drops.
- Same request with out_ready toggling 1,0,0,1,... -> exactly 3 bytes in order, data stable while stalled, mem_rden never causes more than FIFO_DEPTH outstanding bytes.
- len=0, fd=2 -> done falls for exactly one cycle then rises; out_valid never 1; bytes_sent unchanged.
- fd=7 with NUM_FD=4, len=5 -> err_bad_fd=1, mem_rden never asserted, no output; err_bad_fd cleared at the next accepted valid req.
- addr=0xFFE, len=4, MEM_BITS=12 -> mem_addr sequence 0xFFE, 0xFFF, 0x000, 0x001.
- rst=0 asserted after 2 of 6 bytes with out_ready=1 -> next cycle done=1, out_valid=0, FIFO empty, bytes_sent=0; a new req afterwards streams normally.
- Repeat the back-pressure scenario with RD_LAT=3, FIFO_DEPTH=4.
